// File: rtl/mod_sched_pkg.sv
// -----------------------------------------------------------------------------
// mod_sched_pkg
//   Shared types and constants of the modulation segment scheduler.
//   - mod_sched_state_t : scheduler FSM states (RUN, PENDING, STOPPED)
//   - REP_INFINITE      : REP value meaning "loop forever"
//   - eff_div()         : maps a FREQ_DIV of 0 onto 1
// -----------------------------------------------------------------------------
package mod_sched_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    STOPPED = 2'd2
  } mod_sched_state_t;

  localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;
  localparam int          IDX_W        = 15;

  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/mod_settings_pkg.sv
// -----------------------------------------------------------------------------
// mod_settings_pkg
//   Settings published by the controller for the two modulation segments.
//   UPDATE is a one-cycle strobe; all other fields are levels that are
//   sampled only on the UPDATE cycle.
//
//   CYCLE_x    : last sample index of segment x (length - 1)
//   FREQ_DIV_x : STEP divide ratio of segment x (0 behaves as 1)
//   REP_x      : loops after activation (32'hFFFF_FFFF = infinite, 0 = one loop)
// -----------------------------------------------------------------------------
package mod_settings_pkg;

  typedef struct packed {
    logic        UPDATE;
    logic        REQ_RD_SEGMENT;
    logic [14:0] CYCLE_0;
    logic [31:0] FREQ_DIV_0;
    logic [31:0] REP_0;
    logic [14:0] CYCLE_1;
    logic [31:0] FREQ_DIV_1;
    logic [31:0] REP_1;
  } mod_settings_t;

endpackage

// File: rtl/mod_sched_divider.sv
// -----------------------------------------------------------------------------
// mod_sched_divider
//   32-bit STEP divider. The count advances on every STEP and wraps to 0 when
//   it reaches div-1; that STEP produces the sample event sev (combinational,
//   the parent registers everything derived from it).
//
//   Ports:
//     clk   in   clock
//     rst   in   asynchronous active-high reset
//     clr   in   synchronous clear, wins over step
//     step  in   base sampling tick
//     div   in   effective divide ratio, always >= 1
//     sev   out  sample event, high during the STEP that completes division
// -----------------------------------------------------------------------------
module mod_sched_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        step,
  input  logic [31:0] div,
  output logic        sev
);

  logic [31:0] cnt;

  // ">=" rather than "==": after a same-segment UPDATE lowers the ratio the
  // count may already be past the new terminal value; it then wraps on the
  // next STEP instead of running through the full 32-bit range.
  assign sev = step && (cnt >= (div - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= sev ? 32'd0 : (cnt + 32'd1);
    end
  end

endmodule

// File: rtl/mod_segment_scheduler.sv
// -----------------------------------------------------------------------------
// mod_segment_scheduler
//   Plays back one of two modulation segments: divides STEP by the active
//   segment's FREQ_DIV, walks IDX from 0 to CYCLE, counts loops against REP
//   and switches segment on request.
//
//   Build option MOD_SCHED_IMMEDIATE_SWITCH_EN:
//     undefined : a segment-changing UPDATE waits for the next loop boundary
//                 (PENDING state), or the next sample event when STOPPED.
//     defined   : a segment-changing UPDATE switches one cycle after the strobe.
//
//   Ports:
//     CLK           in   system clock
//     RST           in   asynchronous active-high reset
//     STEP          in   one-cycle base sampling tick
//     MOD_SETTINGS  in   segment configuration, UPDATE is a one-cycle strobe
//     IDX           out  current sample index in the active segment
//     SEGMENT       out  active segment
//     IDX_VALID     out  one-cycle pulse when IDX/SEGMENT advance or change
//     SWITCHED      out  one-cycle pulse on the cycle a switch takes effect
//     STOP          out  high while halted after a finite REP ran out
//     state_dbg     out  current FSM state
//
//   Interface semantics: there is no valid/ready handshake. STEP and UPDATE
//   are fire-and-forget strobes that are always accepted in the cycle they are
//   high; IDX_VALID is a pure strobe with no back-pressure. All outputs are
//   registered.
// -----------------------------------------------------------------------------
module mod_segment_scheduler
  import mod_sched_pkg::*;
  import mod_settings_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                STEP,
  input  mod_settings_t       MOD_SETTINGS,
  output logic [IDX_W-1:0]    IDX,
  output logic                SEGMENT,
  output logic                IDX_VALID,
  output logic                SWITCHED,
  output logic                STOP,
  output mod_sched_state_t    state_dbg
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  mod_sched_state_t state;
  logic             pend_seg;   // segment to switch to
  logic             stop_sw;    // switch requested while STOPPED
  logic [31:0]      loop_cnt;

  // Latched per-segment parameters, indexed by segment number.
  logic [IDX_W-1:0] cyc_r [2];
  logic [31:0]      div_r [2];
  logic [31:0]      rep_r [2];

  logic [IDX_W-1:0] act_cyc;
  logic [31:0]      act_div;
  logic [31:0]      act_rep;
  logic             sev;

  assign act_cyc   = cyc_r[SEGMENT];
  assign act_div   = eff_div(div_r[SEGMENT]);
  assign act_rep   = rep_r[SEGMENT];
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  mod_sched_state_t n_state;
  logic             n_seg;
  logic             n_pend;
  logic             n_stop_sw;
  logic [IDX_W-1:0] n_idx;
  logic [31:0]      n_loop;
  logic             n_valid;
  logic             n_sw;
  logic             div_clr;
  logic             sw_now;
  logic             same_seg;
  logic             lat0;
  logic             lat1;
  logic [IDX_W-1:0] req_cyc;
  logic [IDX_W-1:0] n_cyc [2];
  logic [31:0]      n_div [2];
  logic [31:0]      n_rep [2];

  mod_sched_divider u_divider (
    .clk  (CLK),
    .rst  (RST),
    .clr  (div_clr),
    .step (STEP),
    .div  (act_div),
    .sev  (sev)
  );

  // The STEP/SEV part is evaluated first with the current parameters and
  // state; an UPDATE in the same cycle is then applied on top of that result.
  always_comb begin
    n_state   = state;
    n_seg     = SEGMENT;
    n_pend    = pend_seg;
    n_stop_sw = stop_sw;
    n_idx     = IDX;
    n_loop    = loop_cnt;
    n_valid   = 1'b0;
    n_sw      = 1'b0;
    div_clr   = 1'b0;
    sw_now    = 1'b0;
    same_seg  = 1'b0;
    lat0      = 1'b0;
    lat1      = 1'b0;
    req_cyc   = '0;
    n_cyc[0]  = cyc_r[0];
    n_cyc[1]  = cyc_r[1];
    n_div[0]  = div_r[0];
    n_div[1]  = div_r[1];
    n_rep[0]  = rep_r[0];
    n_rep[1]  = rep_r[1];

    // ---- sample event ----
    if (sev) begin
      if (state == STOPPED) begin
        // Halted: only a switch requested while stopped can wake us up.
        sw_now = stop_sw;
      end else if (IDX < act_cyc) begin
        n_idx   = IDX + 15'd1;
        n_valid = 1'b1;
      end else if (state == PENDING) begin
        // A pending switch beats STOPPED entry at the same boundary.
        sw_now = 1'b1;
      end else if ((act_rep != REP_INFINITE) && (loop_cnt == act_rep)) begin
        n_state = STOPPED;
        n_idx   = act_cyc;
      end else begin
        n_idx   = '0;
        n_loop  = loop_cnt + 32'd1;
        n_valid = 1'b1;
      end
    end

    if (sw_now) begin
      n_seg     = pend_seg;
      n_idx     = '0;
      n_loop    = '0;
      div_clr   = 1'b1;
      n_sw      = 1'b1;
      n_valid   = 1'b1;
      n_state   = RUN;
      n_stop_sw = 1'b0;
    end

    // ---- settings update ----
    if (MOD_SETTINGS.UPDATE) begin
      same_seg = (MOD_SETTINGS.REQ_RD_SEGMENT == n_seg);
      // The non-active segment is always re-latched; the active one only when
      // it is the one being requested.
      lat0     = (n_seg != 1'b0) || same_seg;
      lat1     = (n_seg != 1'b1) || same_seg;
      req_cyc  = MOD_SETTINGS.REQ_RD_SEGMENT ? MOD_SETTINGS.CYCLE_1
                                             : MOD_SETTINGS.CYCLE_0;
      if (lat0) begin
        n_cyc[0] = MOD_SETTINGS.CYCLE_0;
        n_div[0] = MOD_SETTINGS.FREQ_DIV_0;
        n_rep[0] = MOD_SETTINGS.REP_0;
      end
      if (lat1) begin
        n_cyc[1] = MOD_SETTINGS.CYCLE_1;
        n_div[1] = MOD_SETTINGS.FREQ_DIV_1;
        n_rep[1] = MOD_SETTINGS.REP_1;
      end

      if (same_seg) begin
        // Re-arm the active segment: also cancels any pending switch.
        n_loop    = '0;
        n_state   = RUN;
        n_stop_sw = 1'b0;
        if (n_idx > req_cyc) begin
          n_idx   = '0;
          n_valid = 1'b1;
        end
      end else begin
`ifdef MOD_SCHED_IMMEDIATE_SWITCH_EN
        n_seg     = MOD_SETTINGS.REQ_RD_SEGMENT;
        n_idx     = '0;
        n_loop    = '0;
        div_clr   = 1'b1;
        n_sw      = 1'b1;
        n_valid   = 1'b1;
        n_state   = RUN;
        n_stop_sw = 1'b0;
`else
        n_pend = MOD_SETTINGS.REQ_RD_SEGMENT;
        case (n_state)
          RUN:     n_state   = PENDING;
          PENDING: n_state   = PENDING;
          STOPPED: n_stop_sw = 1'b1;
          default: n_state   = RUN;
        endcase
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      SEGMENT   <= 1'b0;
      pend_seg  <= 1'b0;
      stop_sw   <= 1'b0;
      IDX       <= '0;
      loop_cnt  <= '0;
      IDX_VALID <= 1'b0;
      SWITCHED  <= 1'b0;
      STOP      <= 1'b0;
      cyc_r[0]  <= '0;
      div_r[0]  <= 32'd1;
      rep_r[0]  <= REP_INFINITE;
      cyc_r[1]  <= '0;
      div_r[1]  <= 32'd1;
      rep_r[1]  <= REP_INFINITE;
    end else begin
      state     <= n_state;
      SEGMENT   <= n_seg;
      pend_seg  <= n_pend;
      stop_sw   <= n_stop_sw;
      IDX       <= n_idx;
      loop_cnt  <= n_loop;
      IDX_VALID <= n_valid;
      SWITCHED  <= n_sw;
      STOP      <= (n_state == STOPPED);
      cyc_r[0]  <= n_cyc[0];
      div_r[0]  <= n_div[0];
      rep_r[0]  <= n_rep[0];
      cyc_r[1]  <= n_cyc[1];
      div_r[1]  <= n_div[1];
      rep_r[1]  <= n_rep[1];
    end
  end

endmodule

// File: tb/tb_mod_segment_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mod_segment_scheduler
//   Directed bench for mod_segment_scheduler. Expected samples
//   {SEGMENT, SWITCHED, IDX} are queued as stimulus is driven and popped on
//   every IDX_VALID pulse.
// -----------------------------------------------------------------------------
module tb_mod_segment_scheduler;
  import mod_settings_pkg::*;
  import mod_sched_pkg::*;

  // ---- clock / reset ----
  logic             CLK;
  logic             RST;
  logic             STEP;
  mod_settings_t    ms;
  logic [14:0]      IDX;
  logic             SEGMENT;
  logic             IDX_VALID;
  logic             SWITCHED;
  logic             STOP;
  mod_sched_state_t state_dbg;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  mod_segment_scheduler dut (
    .CLK          (CLK),
    .RST          (RST),
    .STEP         (STEP),
    .MOD_SETTINGS (ms),
    .IDX          (IDX),
    .SEGMENT      (SEGMENT),
    .IDX_VALID    (IDX_VALID),
    .SWITCHED     (SWITCHED),
    .STOP         (STOP),
    .state_dbg    (state_dbg)
  );

  // ---- scoreboard ----
  logic [16:0] exp_q[$];
  int          n_asserts = 0;
  int          n_fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic seg, input logic sw, input logic [14:0] idx);
    exp_q.push_back({seg, sw, idx});
  endtask

  task automatic check_outputs();
    logic [16:0] e;
    if (IDX_VALID) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_idx_valid", 32'(IDX_VALID), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 32'({SEGMENT, SWITCHED, IDX}), 32'(e));
      end
    end else begin
      chk("switched_without_valid", 32'(SWITCHED), 32'd0);
    end
  endtask

  task automatic drain(input string tag);
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---- driver tasks ----
  task automatic cycle(input logic s, input logic u);
    STEP      = s;
    ms.UPDATE = u;
    @(posedge CLK);
    #1;
    STEP      = 1'b0;
    ms.UPDATE = 1'b0;
    check_outputs();
  endtask

  task automatic step_once();
    cycle(1'b1, 1'b0);
    repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_ms(input logic req,
                        input logic [14:0] c0, input logic [31:0] d0, input logic [31:0] r0,
                        input logic [14:0] c1, input logic [31:0] d1, input logic [31:0] r1);
    ms.REQ_RD_SEGMENT = req;
    ms.CYCLE_0        = c0;
    ms.FREQ_DIV_0     = d0;
    ms.REP_0          = r0;
    ms.CYCLE_1        = c1;
    ms.FREQ_DIV_1     = d1;
    ms.REP_1          = r1;
  endtask

  // ---- directed sequence ----
  initial begin
    RST  = 1'b1;
    STEP = 1'b0;
    ms   = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_idx",       32'(IDX),       32'd0);
    chk("reset_segment",   32'(SEGMENT),   32'd0);
    chk("reset_idx_valid", 32'(IDX_VALID), 32'd0);
    chk("reset_switched",  32'(SWITCHED),  32'd0);
    chk("reset_stop",      32'(STOP),      32'd0);
    chk("reset_state",     32'(state_dbg), 32'(RUN));
    RST = 1'b0;

    // Basic stepping: CYCLE=3, FREQ_DIV=2 -> a sample every 2nd STEP.
    do_reset();
    set_ms(1'b0, 15'd3, 32'd2, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k % 2 == 0) exp_push(1'b0, 1'b0, 15'((k / 2) % 4));
      step_once();
    end
    drain("basic_drain");

    // Finite REP=1 on CYCLE=1: 1,0,1 then stop holding IDX=1.
    do_reset();
    set_ms(1'b0, 15'd1, 32'd1, 32'd1, 15'd0, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    exp_push(1'b0, 1'b0, 15'd0); step_once();
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    step_once();
    chk("stop_asserted", 32'(STOP),      32'd1);
    chk("stop_idx_hold", 32'(IDX),       32'd1);
    chk("stop_state",    32'(state_dbg), 32'(STOPPED));
    repeat (3) step_once();
    chk("stop_still",    32'(STOP),      32'd1);
    drain("stop_drain");
    // Switch requested while stopped fires on the next sample event.
    set_ms(1'b1, 15'd1, 32'd1, 32'd1, 15'd2, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    chk("stopped_req_stop", 32'(STOP), 32'd1);
    exp_push(1'b1, 1'b1, 15'd0); step_once();
    chk("stopped_switch_stop_clear", 32'(STOP), 32'd0);
    exp_push(1'b1, 1'b0, 15'd1); step_once();
    drain("stopped_switch_drain");

    // Boundary switch: request segment 1 at IDX=1 of CYCLE=3.
    do_reset();
    set_ms(1'b0, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    set_ms(1'b1, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    chk("boundary_pending", 32'(state_dbg), 32'(PENDING));
    exp_push(1'b0, 1'b0, 15'd2); step_once();
    exp_push(1'b0, 1'b0, 15'd3); step_once();
    exp_push(1'b1, 1'b1, 15'd0); step_once();
    chk("boundary_segment", 32'(SEGMENT),   32'd1);
    chk("boundary_run",     32'(state_dbg), 32'(RUN));
    exp_push(1'b1, 1'b0, 15'd1); step_once();
    drain("boundary_drain");

    // Double request cancels the switch; FREQ_DIV=0 behaves as 1.
    do_reset();
    set_ms(1'b0, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    set_ms(1'b1, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    chk("cancel_pending", 32'(state_dbg), 32'(PENDING));
    set_ms(1'b0, 15'd3, 32'd0, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    chk("cancel_run", 32'(state_dbg), 32'(RUN));
    exp_push(1'b0, 1'b0, 15'd2); step_once();
    exp_push(1'b0, 1'b0, 15'd3); step_once();
    exp_push(1'b0, 1'b0, 15'd0); step_once();
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    chk("cancel_segment", 32'(SEGMENT), 32'd0);
    drain("cancel_drain");

    // UPDATE and STEP together: the step still uses FREQ_DIV=1.
    do_reset();
    set_ms(1'b0, 15'd7, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    set_ms(1'b0, 15'd7, 32'd3, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    exp_push(1'b0, 1'b0, 15'd1);
    cycle(1'b1, 1'b1);
    step_once();
    step_once();
    exp_push(1'b0, 1'b0, 15'd2); step_once();
    drain("collision_drain");

    // Reset while PENDING: immediate clear, request discarded.
    do_reset();
    set_ms(1'b0, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    set_ms(1'b1, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    chk("rst_pre_pending", 32'(state_dbg), 32'(PENDING));
    #4;
    RST = 1'b1;
    #1;
    chk("rst_async_idx",     32'(IDX),       32'd0);
    chk("rst_async_segment", 32'(SEGMENT),   32'd0);
    chk("rst_async_stop",    32'(STOP),      32'd0);
    chk("rst_async_state",   32'(state_dbg), 32'(RUN));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drain("rst_pre_drain");
    // Default segment 0 is CYCLE=0: every sample wraps to 0, never switches.
    repeat (4) begin
      exp_push(1'b0, 1'b0, 15'd0);
      step_once();
    end
    chk("rst_no_switch_segment", 32'(SEGMENT), 32'd0);
    drain("rst_post_drain");

`ifdef MOD_SCHED_IMMEDIATE_SWITCH_EN
    // Immediate switch at IDX=2.
    do_reset();
    set_ms(1'b0, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    exp_push(1'b0, 1'b0, 15'd2); step_once();
    set_ms(1'b1, 15'd3, 32'd1, REP_INFINITE, 15'd5, 32'd1, REP_INFINITE);
    exp_push(1'b1, 1'b1, 15'd0);
    cycle(1'b0, 1'b1);
    chk("imm_segment", 32'(SEGMENT),   32'd1);
    chk("imm_state",   32'(state_dbg), 32'(RUN));
    exp_push(1'b1, 1'b0, 15'd1); step_once();
    drain("imm_drain");
`else
    // REP=0 plays exactly one loop then stops at CYCLE.
    do_reset();
    set_ms(1'b0, 15'd2, 32'd1, 32'd0, 15'd5, 32'd1, REP_INFINITE);
    cycle(1'b0, 1'b1);
    exp_push(1'b0, 1'b0, 15'd1); step_once();
    exp_push(1'b0, 1'b0, 15'd2); step_once();
    step_once();
    chk("rep0_stop", 32'(STOP), 32'd1);
    chk("rep0_idx",  32'(IDX),  32'd2);
    drain("rep0_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
